alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the datapath single-cycle ALU, for the next-generation core's execute stage.
- Keeps the single-cycle operation set (add, sub, and, or, slt) with one registered cycle of latency.
- Adds xor, nor, unsigned compare, shifts, and iterative multiply/divide/remainder.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall on long operations.

---
 rtl/alu_mc.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU for the execute stage. Single-cycle ops
//             (add/sub/and/or/xor/slt/sltu/nor/sll/srl/sra) return one
//             registered cycle after acceptance. Iterative ops (mul, signed
//             div, signed rem) take WIDTH steps plus one sign-correction
//             cycle. Valid/ready handshake on both sides; no overlap.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid/in_ready   - operation handshake
//             src_a, src_b, alu_ctrl - operands and 4-bit opcode
//             out_valid/out_ready - result handshake
//             alu_res, zero   - registered result and its zero flag
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  // Iteration registers, shared between multiply and divide:
  //   mul: r_x = partial product, r_y = multiplier (shifts right),
  //        r_z = multiplicand (shifts left)
  //   div: r_x = partial remainder, r_y = dividend magnitude shifting out
  //        while quotient bits shift in, r_z = divisor magnitude
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;

  logic             w_in_multi;
  logic             w_is_multi;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [CNT_W-2:0] w_shamt;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_mul_x;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_multi_res;
  logic [WIDTH-1:0] w_result;

  assign w_in_multi = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
  assign w_is_multi = (r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_last     = (r_cnt == CNT_W'(WIDTH));
  // Single-cycle ops spend exactly one BUSY cycle; iterative ops leave BUSY
  // on the cycle after the last step, which applies sign correction.
  assign w_finish   = (r_state == S_BUSY) && (!w_is_multi || w_last);

  assign w_abs_a = src_a[WIDTH-1] ? -src_a : src_a;
  assign w_abs_b = src_b[WIDTH-1] ? -src_b : src_b;
  assign w_shamt = r_b[CNT_W-2:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_finish) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- single-cycle ops
  always_comb begin
    w_single = '0;
    case (r_op)
      OP_ADD:  w_single = r_a + r_b;
      OP_SUB:  w_single = r_a - r_b;
      OP_AND:  w_single = r_a & r_b;
      OP_OR:   w_single = r_a | r_b;
      OP_XOR:  w_single = r_a ^ r_b;
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      OP_NOR:  w_single = ~(r_a | r_b);
      OP_SLL:  w_single = r_a << w_shamt;
      OP_SRL:  w_single = r_a >> w_shamt;
      OP_SRA:  w_single = $signed(r_a) >>> w_shamt;
      default: w_single = '0;
    endcase
  end

  // ------------------------------------------------------ iterative steps
  assign w_mul_x     = r_y[0] ? (r_x + r_z) : r_x;
  assign w_div_shift = {r_x, r_y[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_z};
  // Partial remainder stays below the divisor, so the shifted value is
  // below twice the divisor and the borrow bit alone decides the compare.
  assign w_div_ge    = ~w_div_diff[WIDTH];

  // Quotient negative when operand signs differ; remainder follows A.
  assign w_q      = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_y : r_y;
  assign w_r      = r_a[WIDTH-1] ? -r_x : r_x;
  assign w_b_zero = (r_b == '0);

  // Most-negative / -1 needs no special case: the magnitude quotient is
  // 2^(WIDTH-1), whose negation wraps back to A, and the remainder is 0.
  always_comb begin
    w_multi_res = '0;
    case (r_op)
      OP_MUL:  w_multi_res = r_x;
      OP_DIV:  w_multi_res = w_b_zero ? '1  : w_q;
      OP_REM:  w_multi_res = w_b_zero ? r_a : w_r;
      default: w_multi_res = '0;
    endcase
  end

  assign w_result = w_is_multi ? w_multi_res : w_single;

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_res  <= '0;
      r_zero <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= src_a;
            r_b   <= src_b;
            r_op  <= alu_ctrl;
            r_cnt <= '0;
            r_x   <= '0;
            // Low product bits do not depend on signedness, so multiply
            // works on the raw bit patterns; divide uses magnitudes.
            if (w_in_multi && (alu_ctrl == OP_MUL)) begin
              r_y <= src_b;
              r_z <= src_a;
            end else begin
              r_y <= w_abs_a;
              r_z <= w_abs_b;
            end
          end
        end
        S_BUSY: begin
          if (w_finish) begin
            r_res  <= w_result;
            r_zero <= (w_result == '0);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op == OP_MUL) begin
              r_x <= w_mul_x;
              r_y <= r_y >> 1;
              r_z <= r_z << 1;
            end else begin
              r_x <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
              r_y <= {r_y[WIDTH-2:0], w_div_ge};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_res = r_res;
  assign zero    = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Self-checking bench for alu_mc (WIDTH=32): directed cases,
//             backpressure, mid-operation reset and random operations,
//             checked against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_res;
  logic         zero;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_ctrl (alu_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_res  (alu_res),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [4:0]         sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'd0, (sa < sb)};
      4'd6:  return {31'd0, (a < b)};
      4'd7:  return ~(a | b);
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return sa >>> sh;
      4'd12: return a * b;
      4'd13: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      4'd14: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Issue one operation from IDLE, wait for the result, optionally stall
  // the consumer for `hold` cycles, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    logic [31:0] exp;
    int          lat;
    int          explat;
    exp    = model(op, a, b);
    explat = (op == 4'd12 || op == 4'd13 || op == 4'd14) ? W + 1 : 1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    src_a    = a;
    src_b    = b;
    alu_ctrl = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (poke) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        src_a    = $urandom;
        src_b    = $urandom;
        alu_ctrl = 4'd0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(explat));
    chk("result", alu_res, exp);
    chk("zero", 32'(zero), {31'd0, (exp == 32'd0)});
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", alu_res, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    // Reset with in_valid asserted: the request must be ignored.
    rst       = 1'b1;
    in_valid  = 1'b1;
    src_a     = 32'd1;
    src_b     = 32'd2;
    alu_ctrl  = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_res", alu_res, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    chk("rst_ignored", 32'(out_valid), 32'd0);

    // Directed cases.
    run_op(4'd0,  32'h7FFF_FFFF, 32'd1, 0, 0);
    chk("add_const", alu_res, 32'h8000_0000);
    run_op(4'd1,  32'd5, 32'd5, 0, 0);
    chk("sub_zero", 32'(zero), 32'd1);
    run_op(4'd5,  32'hFFFF_FFFF, 32'd1, 0, 0);
    chk("slt_const", alu_res, 32'd1);
    run_op(4'd6,  32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op(4'd10, 32'h8000_0000, 32'd4, 0, 0);
    chk("sra_const", alu_res, 32'hF800_0000);
    run_op(4'd9,  32'h8000_0000, 32'd4, 0, 0);
    run_op(4'd8,  32'h0000_0001, 32'h0000_003F, 0, 0);
    run_op(4'd7,  32'h0F0F_0000, 32'h0000_F0F0, 0, 0);
    run_op(4'd4,  32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0);
    run_op(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    run_op(4'd12, 32'hFFFF_FFFD, 32'd7, 0, 1);
    chk("mul_const", alu_res, 32'hFFFF_FFEB);
    run_op(4'd13, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_const", alu_res, 32'hFFFF_FFFD);
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("rem_const", alu_res, 32'hFFFF_FFFF);
    run_op(4'd13, 32'd9, 32'd0, 0, 0);
    run_op(4'd14, 32'd9, 32'd0, 0, 0);
    chk("rem0_const", alu_res, 32'd9);
    run_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(4'd13, 32'd100, 32'hFFFF_FFF9, 0, 0);
    run_op(4'd2,  32'hDEAD_BEEF, 32'h0FF0_0FF0, 5, 0);

    // Reset in the middle of a divide: no result may appear.
    in_valid = 1'b1;
    src_a    = 32'd100;
    src_b    = 32'd7;
    alu_ctrl = 4'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_alu_res", alu_res, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    run_op(4'd0, 32'd2, 32'd3, 0, 0);
    chk("after_abort_add", alu_res, 32'd5);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      if (i % 7 == 0) b = 32'd0;
      if (i % 9 == 0) a = 32'h8000_0000;
      run_op(op, a, b, $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
